// File: rtl/dft_bin_accumulator.sv
// dft_bin_accumulator: streaming complex accumulator for one DFT bin.
// Sums N double-precision product pairs, then presents the bin result.
//
// Ports:
//   clk, rst_n          rising-edge clock, async active-low reset
//   in_valid/in_ready   product beat handshake (in_re, in_im: double bits)
//   out_valid/out_ready result handshake (out_re, out_im: double bits)
//   out_bin             index of the bin currently presented (wraps at N)
//   busy                partial sum in progress or result held
//
// Build option: DFT_ACC_SCALE_EN scales each result by 1.0/N.
// Arithmetic is behavioural `real`, matching the upstream Mult stage.

module dft_bin_accumulator #(
    parameter int N = 16,
    parameter int W = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          in_re,
    input  logic [W-1:0]          in_im,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W-1:0]          out_re,
    output logic [W-1:0]          out_im,
    output logic [$clog2(N)-1:0]  out_bin,
    output logic                  busy
);

    localparam int BW = $clog2(N);

    localparam logic [0:0] ACC  = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    localparam logic [BW-1:0] LAST = BW'(N - 1);

`ifdef DFT_ACC_SCALE_EN
    localparam real SCALE = 1.0 / real'(N);
`endif

    logic [0:0]    state;
    logic [BW-1:0] count;
    logic [W-1:0]  acc_re;
    logic [W-1:0]  acc_im;
    logic [W-1:0]  res_re;
    logic [W-1:0]  res_im;
    logic [BW-1:0] bin;

    logic [W-1:0]  sum_re_bits;
    logic [W-1:0]  sum_im_bits;
    logic [W-1:0]  fin_re_bits;
    logic [W-1:0]  fin_im_bits;

    real s_re;
    real s_im;
    real a_re;
    real a_im;
    real sum_re;
    real sum_im;
    real fin_re;
    real fin_im;

    logic take;
    logic give;

    assign in_ready  = (state == ACC);
    assign out_valid = (state == HOLD);
    assign take      = in_valid & in_ready;
    assign give      = out_valid & out_ready;
    assign busy      = (count != '0) | out_valid;

    assign out_re  = res_re;
    assign out_im  = res_im;
    assign out_bin = bin;

    // The first beat of a bin loads rather than adds, so a -0.0 or
    // NaN sample survives exactly as a real sum would treat it.
    always_comb begin
        s_re   = $bitstoreal(in_re);
        s_im   = $bitstoreal(in_im);
        a_re   = $bitstoreal(acc_re);
        a_im   = $bitstoreal(acc_im);
        sum_re = s_re;
        sum_im = s_im;
        if (count != '0) begin
            sum_re = a_re + s_re;
            sum_im = a_im + s_im;
        end
`ifdef DFT_ACC_SCALE_EN
        fin_re = sum_re * SCALE;
        fin_im = sum_im * SCALE;
`else
        fin_re = sum_re;
        fin_im = sum_im;
`endif
        sum_re_bits = $realtobits(sum_re);
        sum_im_bits = $realtobits(sum_im);
        fin_re_bits = $realtobits(fin_re);
        fin_im_bits = $realtobits(fin_im);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ACC;
            count  <= '0;
            acc_re <= '0;
            acc_im <= '0;
            res_re <= '0;
            res_im <= '0;
            bin    <= '0;
        end else begin
            unique case (state)
                ACC: begin
                    if (take) begin
                        if (count == LAST) begin
                            res_re <= fin_re_bits;
                            res_im <= fin_im_bits;
                            count  <= '0;
                            state  <= HOLD;
                        end else begin
                            acc_re <= sum_re_bits;
                            acc_im <= sum_im_bits;
                            count  <= count + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (give) begin
                        state <= ACC;
                        bin   <= (bin == LAST) ? '0 : bin + 1'b1;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_dft_bin_accumulator.sv
// tb_dft_bin_accumulator: directed self-checking bench.
// Covers reset, sum, backpressure, bubbles, bin wrap, mid-bin reset.

module tb_dft_bin_accumulator;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_re;
    logic [63:0] in_im;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_re;
    logic [63:0] out_im;
    logic [3:0]  out_bin;
    logic        busy;

    int total;
    int bad;

`ifdef DFT_ACC_SCALE_EN
    localparam real DIV = 16.0;
`else
    localparam real DIV = 1.0;
`endif

    dft_bin_accumulator #(.N(16), .W(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_bin   (out_bin),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic beat(input real re, input real im);
        in_valid = 1'b1;
        in_re    = $realtobits(re);
        in_im    = $realtobits(im);
        tick();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_re"}, out_re, 64'h0);
        check({tag, "_out_im"}, out_im, 64'h0);
        check({tag, "_out_bin"}, 64'(out_bin), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    logic [63:0] held_re;
    logic [63:0] held_im;

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_re     = '0;
        in_im     = '0;
        out_ready = 1'b1;

        // reset
        @(negedge clk);
        check_reset("rst");
        tick();
        rst_n = 1'b1;
        tick();
        check_reset("rst_rel");

        // basic sum, bin 0
        for (int k = 0; k < 16; k++) begin
            beat(real'(2 * k), real'(2 * k + 1));
            if (k == 0) check("basic_busy", 64'(busy), 64'd1);
            if (k < 15) check("basic_early", 64'(out_valid), 64'd0);
        end
        check("basic_valid", 64'(out_valid), 64'd1);
        check("basic_re", out_re, $realtobits(240.0 / DIV));
        check("basic_im", out_im, $realtobits(256.0 / DIV));
        check("basic_bin", 64'(out_bin), 64'd0);
        check("basic_rdy", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        tick();
        check("basic_once", 64'(out_valid), 64'd0);
        check("basic_rdy2", 64'(in_ready), 64'd1);
        check("basic_bin2", 64'(out_bin), 64'd1);
        check("basic_idle", 64'(busy), 64'd0);

        // backpressure, bin 1
        out_ready = 1'b0;
        for (int k = 0; k < 16; k++) beat(real'(2 * k), real'(2 * k + 1));
        check("bp_valid", 64'(out_valid), 64'd1);
        held_re = out_re;
        held_im = out_im;
        check("bp_re", held_re, $realtobits(240.0 / DIV));
        for (int c = 0; c < 5; c++) begin
            beat(100.0, 200.0);
            check("bp_hold_v", 64'(out_valid), 64'd1);
            check("bp_hold_r", 64'(in_ready), 64'd0);
            check("bp_hold_re", out_re, $realtobits(240.0 / DIV));
            check("bp_hold_im", out_im, $realtobits(256.0 / DIV));
            check("bp_hold_bin", 64'(out_bin), 64'd1);
        end
        out_ready = 1'b1;
        beat(100.0, 200.0);
        check("bp_done_v", 64'(out_valid), 64'd0);
        check("bp_done_r", 64'(in_ready), 64'd1);
        check("bp_noacc", 64'(busy), 64'd0);
        check("bp_bin", 64'(out_bin), 64'd2);
        in_valid = 1'b0;

        // bubbles, bin 2
        for (int k = 0; k < 16; k++) begin
            beat(real'(2 * k), real'(2 * k + 1));
            if (k < 15) begin
                check("bub_early", 64'(out_valid), 64'd0);
                in_valid = 1'b0;
                tick();
                check("bub_gap", 64'(out_valid), 64'd0);
            end
        end
        check("bub_valid", 64'(out_valid), 64'd1);
        check("bub_re", out_re, $realtobits(240.0 / DIV));
        check("bub_im", out_im, $realtobits(256.0 / DIV));
        check("bub_bin", 64'(out_bin), 64'd2);
        in_valid = 1'b0;
        tick();

        // reset during HOLD drops out_valid without a clock
        out_ready = 1'b0;
        for (int k = 0; k < 16; k++) beat(1.0, -1.0);
        check("rh_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rh_drop", 64'(out_valid), 64'd0);
        check("rh_bin", 64'(out_bin), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b0;
        tick();

        // reset mid-bin, 7 beats discarded
        for (int k = 0; k < 7; k++) beat(1.0, -1.0);
        check("rm_busy", 64'(busy), 64'd1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        check_reset("rm");
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) beat(1.0, -1.0);
        check("rm_re", out_re, $realtobits(16.0 / DIV));
        check("rm_im", out_im, $realtobits(-16.0 / DIV));
        check("rm_bin", 64'(out_bin), 64'd0);
        in_valid = 1'b0;
        tick();

        // bin wrap: bins 1..15 then 0
        for (int b = 1; b <= 16; b++) begin
            for (int k = 0; k < 16; k++) beat(1.0, -1.0);
            check("wrap_valid", 64'(out_valid), 64'd1);
            check("wrap_re", out_re, $realtobits(16.0 / DIV));
            check("wrap_im", out_im, $realtobits(-16.0 / DIV));
            check("wrap_bin", 64'(out_bin), 64'(b % 16));
            in_valid = 1'b0;
            tick();
        end
        check("wrap_end", 64'(out_bin), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
